// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// controller state encoding and digit-level constants.
package bcd_pkg;

  // Controller states: waiting for a request, or running shift-add-3 iterations.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width of one packed BCD digit.
  localparam int BCD_DIGIT_W = 4;

  // A digit at or above this value gets +3 before doubling, so that the
  // doubling carries correctly into the next decimal digit.
  localparam int ADJ_THRESHOLD = 5;

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit correction for the double-dabble algorithm: adds 3 to a
// BCD digit of 5 or more so the following left shift yields a valid BCD
// digit plus a decimal carry. Purely combinational.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  // Add 3 when the digit would reach 10 or more after doubling.
  always_comb begin
    adjusted = digit;
    if (digit >= BCD_DIGIT_W'(ADJ_THRESHOLD)) begin
      adjusted = digit + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// A request accepted in IDLE runs exactly W iterations; results, overflow
// and a one-cycle done pulse appear after the last iteration.
// Optional feature: define BIN2BCD_BLANK_EN to add the leading-zero
// "blank" output, registered together with bcd.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int W      = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [W-1:0]                  bin_in,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]             blank
`endif
);

  localparam int BW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(W + 1);

  // Reject illegal configurations while elaborating.
  generate
    if (W < 4 || W > 32 || DIGITS < 1 || DIGITS > 10) begin : g_bad_param
      $error("bin2bcd_seq: W must be 4..32 and DIGITS must be 1..10");
    end
  endgenerate

  state_t          state_reg, state_next;
  logic [W-1:0]    shreg_reg;
  logic [BW-1:0]   acc_reg;
  logic            ovf_track_reg;
  logic [CW-1:0]   cnt_reg;
  logic [BW-1:0]   bcd_reg;
  logic            ovf_reg;
  logic            done_reg;

  logic [BW-1:0]   adj;
  logic [BW-1:0]   acc_shift;
  logic [W-1:0]    shreg_shift;
  logic            carry_out;
  logic            last_iter;

  // One corrector per digit of the accumulator.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit    (acc_reg[BCD_DIGIT_W*gi +: BCD_DIGIT_W]),
        .adjusted (adj[BCD_DIGIT_W*gi +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // Shift {adjusted accumulator, binary} left by one; the bit leaving the
  // top digit means the value no longer fits in DIGITS decimal digits.
  assign acc_shift   = {adj[BW-2:0], shreg_reg[W-1]};
  assign carry_out   = adj[BW-1];
  assign shreg_shift = {shreg_reg[W-2:0], 1'b0};
  assign last_iter   = (state_reg == SHIFT) && (cnt_reg == CW'(1));

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_reg;
  logic [DIGITS-1:0] blank_next;

  // Digit i is blank when it and every digit above it are zero; the ones
  // digit is always shown.
  assign blank_next[0] = 1'b0;
  generate
    for (gi = 1; gi < DIGITS; gi++) begin : g_blank
      assign blank_next[gi] = (acc_shift[BW-1:BCD_DIGIT_W*gi] == '0);
    end
  endgenerate

  // Register the blank mask alongside the BCD result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blank_reg <= '0;
    end else if (last_iter) begin
      blank_reg <= blank_next;
    end
  end

  assign blank = blank_reg;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, leave SHIFT after the W-th iteration.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)     state_next = SHIFT;
      SHIFT:   if (last_iter) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: busy covers exactly the SHIFT cycles.
  always_comb begin
    busy = (state_reg == SHIFT);
  end

  // Datapath: load on accept, iterate in SHIFT, publish results on the last edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_reg     <= '0;
      acc_reg       <= '0;
      ovf_track_reg <= 1'b0;
      cnt_reg       <= '0;
      bcd_reg       <= '0;
      ovf_reg       <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            shreg_reg     <= bin_in;
            acc_reg       <= '0;
            ovf_track_reg <= 1'b0;
            cnt_reg       <= CW'(W);
          end
        end
        SHIFT: begin
          shreg_reg     <= shreg_shift;
          acc_reg       <= acc_shift;
          ovf_track_reg <= ovf_track_reg | carry_out;
          cnt_reg       <= cnt_reg - CW'(1);
          if (last_iter) begin
            bcd_reg  <= acc_shift;
            ovf_reg  <= ovf_track_reg | carry_out;
            done_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bcd      = bcd_reg;
  assign overflow = ovf_reg;
  assign done     = done_reg;

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter W, default 8: binary input width, legal range 4..32.
REQ-002 SHALL have parameter DIGITS, default 3: number of BCD output digits, legal range 1..10.
REQ-003 SHALL have port clk, input, 1 bit: sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: conversion request; sampled only in IDLE.
REQ-006 SHALL have port bin_in, input, W bits: unsigned value, captured on the accepting edge.
REQ-007 SHALL have port bcd, output, 4*DIGITS bits: digit i is in bits [4i+3:4i]; digit 0 is the ones digit.
REQ-008 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking that bcd, overflow (and blank) are updated.
REQ-010 SHALL have port overflow, output, 1 bit: high when the value is at least 10^DIGITS.

Function
REQ-011 SHALL implement the states IDLE and SHIFT.
REQ-012 SHALL, when in IDLE with start=1 at edge E0, load bin_in into the shift register, clear the digit accumulator and the overflow tracker, set the iteration count to W, and move to SHIFT.
REQ-013 SHALL, at each edge in SHIFT, add 3 to every accumulator digit greater than 4, then shift {accumulator, shift register} left by one bit, with the MSB of bin entering digit 0.
REQ-014 SHALL set the overflow tracker whenever a 1 is shifted out of the top digit during any iteration.
REQ-015 SHALL perform exactly W iterations, at edges E1..EW.
REQ-016 SHALL, at edge EW, register bcd and overflow, assert done for the following cycle only, and return to IDLE; latency is W cycles from the accepting edge.
REQ-017 SHALL hold busy=1 in every cycle after E0 up to and including edge EW, and busy=0 in IDLE.
REQ-018 SHALL ignore start while busy=1; bin_in changes during SHIFT SHALL have no effect.
REQ-019 SHALL accept a start that is high in the done cycle, because that cycle is in IDLE; conversions therefore run back-to-back with a period of W+1 cycles.
REQ-020 SHALL hold bcd and overflow stable between done pulses.
REQ-021 SHALL, on overflow, output the low DIGITS digits of the true decimal value, modulo 10^DIGITS.

Reset
REQ-022 SHALL, when rst_n=0 at a rising edge, force state=IDLE, bcd=0, busy=0, done=0, overflow=0, and clear all internal registers.
REQ-023 SHALL abort any conversion in progress on reset, with no done pulse issued for it.
REQ-024 SHALL ignore start in any cycle in which rst_n=0.

Configuration
REQ-025 SHALL, when macro BIN2BCD_BLANK_EN is defined, add output port blank, DIGITS bits; bit i=1 iff digit i and all higher digits are zero, for i>0; bit 0 is always 0.
REQ-026 SHALL register blank together with bcd at edge EW and reset it to 0.
REQ-027 SHALL, without BIN2BCD_BLANK_EN, have no blank port and no blank logic.

Structure
REQ-028 SHALL take its state enumeration type, a BCD_DIGIT_W=4 constant and an ADJ_THRESHOLD=5 constant from the shared package bcd_pkg.
REQ-029 SHALL instantiate one combinational sub-module, bcd_digit_adj (4-bit in, 4-bit out, adds 3 when the input is at least 5), once per digit.
REQ-030 SHALL check parameter legality at elaboration.

Verification
REQ-031 W=8, DIGITS=3, bin_in=255 with a start pulse -> done exactly 8 cycles after the accepting edge; bcd=12'h255; overflow=0.
REQ-032 W=16, DIGITS=5, bin_in=65535 -> done after 16 cycles; bcd=20'h65535; then bin_in=0 -> bcd=0.
REQ-033 W=8, DIGITS=2, bin_in=100 -> overflow=1; bcd=8'h00. Then bin_in=99 -> overflow=0; bcd=8'h99.
REQ-034 start held high continuously with bin_in changing each cycle -> only values present at accepting edges are converted; done pulses every 9 cycles (W=8); busy is never low for more than one cycle.
REQ-035 rst_n=0 at iteration 4 of a conversion of 200 -> no done pulse; all outputs 0; a following start with 42 -> bcd=12'h042.
REQ-036 With BIN2BCD_BLANK_EN, W=8, DIGITS=3: bin_in=7 -> blank=3'b110; bin_in=0 -> blank=3'b110; bin_in=105 -> blank=3'b000.
